// File: rtl/pong_pkg.sv
// Shared definitions for the pong paddle datapath.
//   paddle_state_t : per-channel movement FSM state
//   speed_width()  : bits needed to hold a step size of 1..max_speed
//   max_pos()      : lowest legal top-line y (paddle fully on screen)
//   center()       : reset position, midway between 0 and max_pos
package pong_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE_UP   = 2'd1,
    MOVE_DOWN = 2'd2
  } paddle_state_t;

  function automatic int speed_width(input int max_speed);
    return $clog2(max_speed + 1);
  endfunction

  function automatic int max_pos(input int screen_height, input int paddle_height);
    return screen_height - paddle_height;
  endfunction

  function automatic int center(input int screen_height, input int paddle_height);
    return (screen_height - paddle_height) / 2;
  endfunction

endpackage

// File: rtl/paddle_channel.sv
// One paddle: button synchronisers, movement FSM, speed ramp and clamped
// position register.
//   clk, reset : system clock, synchronous active-high reset
//   up, down   : raw (asynchronous) buttons
//   tick       : movement strobe shared by all channels
//   freeze     : hold paddle; FSM forced idle on ticks
//   pos        : top-line y of the paddle
module paddle_channel
  import pong_pkg::*;
#(
  parameter int POS_W       = 10,
  parameter int MAX_POS     = 416,
  parameter int CENTER      = 208,
  parameter int MAX_SPEED   = 8,
  parameter int ACCEL_TICKS = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             up,
  input  logic             down,
  input  logic             tick,
  input  logic             freeze,
  output logic [POS_W-1:0] pos
);

  localparam int SPD_W  = speed_width(MAX_SPEED);
  localparam int HOLD_W = (ACCEL_TICKS > 1) ? $clog2(ACCEL_TICKS) : 1;
  localparam logic [POS_W:0]    MAX_POS_X = (POS_W+1)'(MAX_POS);
  localparam logic [SPD_W-1:0]  SPD_ONE   = SPD_W'(1);
  localparam logic [SPD_W-1:0]  SPD_MAX   = SPD_W'(MAX_SPEED);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(ACCEL_TICKS - 1);

  logic [1:0]        up_sync, down_sync;
  paddle_state_t     state, state_nxt, dir;
  logic [SPD_W-1:0]  speed, speed_nxt, step;
  logic [HOLD_W-1:0] hold, hold_nxt;
  logic [POS_W-1:0]  pos_nxt;
  logic              move;
  logic [POS_W:0]    pos_x, step_x, up_val, dn_sum, dn_val;

  always_ff @(posedge clk) begin
    if (reset) begin
      up_sync   <= '0;
      down_sync <= '0;
      state     <= IDLE;
      speed     <= SPD_ONE;
      hold      <= '0;
      pos       <= POS_W'(CENTER);
    end else begin
      up_sync   <= {up_sync[0], up};
      down_sync <= {down_sync[0], down};
      state     <= state_nxt;
      speed     <= speed_nxt;
      hold      <= hold_nxt;
      pos       <= pos_nxt;
    end
  end

  // Both buttons or neither cancel each other out.
  always_comb begin
    dir = IDLE;
    if (up_sync[1] && !down_sync[1])      dir = MOVE_UP;
    else if (down_sync[1] && !up_sync[1]) dir = MOVE_DOWN;
  end

  always_comb begin
    state_nxt = state;
    speed_nxt = speed;
    hold_nxt  = hold;
    step      = SPD_ONE;
    move      = 1'b0;
    if (tick) begin
      if (freeze || dir == IDLE) begin
        state_nxt = IDLE;
        speed_nxt = SPD_ONE;
        hold_nxt  = '0;
      end else if (dir != state) begin
        // Entry or reversal always restarts the ramp with a single-line step.
        state_nxt = dir;
        speed_nxt = SPD_ONE;
        hold_nxt  = '0;
        move      = 1'b1;
      end else begin
        step = speed;
        move = 1'b1;
        if (hold == HOLD_LAST) begin
          hold_nxt = '0;
          if (speed != SPD_MAX) speed_nxt = speed + SPD_ONE;
        end else begin
          hold_nxt = hold + HOLD_W'(1);
        end
      end
    end
  end

  // One extra bit so pos+step can exceed MAX_POS without wrapping.
  always_comb begin
    pos_x   = {1'b0, pos};
    step_x  = (POS_W+1)'(step);
    up_val  = (pos_x < step_x) ? '0 : pos_x - step_x;
    dn_sum  = pos_x + step_x;
    dn_val  = (dn_sum > MAX_POS_X) ? MAX_POS_X : dn_sum;
    pos_nxt = pos;
    if (move) pos_nxt = (dir == MOVE_UP) ? up_val[POS_W-1:0] : dn_val[POS_W-1:0];
  end

endmodule

// File: rtl/paddle_control_n.sv
// N-player paddle controller: shared movement tick divider plus one
// paddle_channel per player.
//   i_clk, i_reset   : system clock, synchronous active-high reset
//   i_up, i_down     : per-player raw buttons
//   i_freeze         : hold all paddles
//   o_paddle_pos     : player k position at [k*POS_W +: POS_W]
//   o_at_top/bottom  : player k at position 0 / MAX_POS
//   o_tick           : one-cycle movement strobe
module paddle_control_n
  import pong_pkg::*;
#(
  parameter int NUM_PLAYERS   = 2,
  parameter int SCREEN_HEIGHT = 480,
  parameter int PADDLE_HEIGHT = 64,
  parameter int POS_W         = 10,
  parameter int TICK_DIV      = 250000,
  parameter int MAX_SPEED     = 8,
  parameter int ACCEL_TICKS   = 4
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic [NUM_PLAYERS-1:0]       i_up,
  input  logic [NUM_PLAYERS-1:0]       i_down,
  input  logic                         i_freeze,
  output logic [NUM_PLAYERS*POS_W-1:0] o_paddle_pos,
  output logic [NUM_PLAYERS-1:0]       o_at_top,
  output logic [NUM_PLAYERS-1:0]       o_at_bottom,
  output logic                         o_tick
);

  localparam int MAX_POS = max_pos(SCREEN_HEIGHT, PADDLE_HEIGHT);
  localparam int CTR     = center(SCREEN_HEIGHT, PADDLE_HEIGHT);
  localparam int CNT_W   = $clog2(TICK_DIV);

  if (NUM_PLAYERS < 1)                 begin : g_bad_np  $error("NUM_PLAYERS must be >= 1"); end
  if (PADDLE_HEIGHT >= SCREEN_HEIGHT)  begin : g_bad_ph  $error("PADDLE_HEIGHT must be < SCREEN_HEIGHT"); end
  if ((2 ** POS_W) < SCREEN_HEIGHT)    begin : g_bad_pw  $error("POS_W too small for SCREEN_HEIGHT"); end
  if (TICK_DIV < 2)                    begin : g_bad_td  $error("TICK_DIV must be >= 2"); end
  if (MAX_SPEED < 1)                   begin : g_bad_ms  $error("MAX_SPEED must be >= 1"); end
  if (ACCEL_TICKS < 1)                 begin : g_bad_at  $error("ACCEL_TICKS must be >= 1"); end

  logic [CNT_W-1:0] tick_cnt;

  assign o_tick = (tick_cnt == CNT_W'(TICK_DIV - 1));

  always_ff @(posedge i_clk) begin
    if (i_reset)     tick_cnt <= '0;
    else if (o_tick) tick_cnt <= '0;
    else             tick_cnt <= tick_cnt + CNT_W'(1);
  end

  for (genvar k = 0; k < NUM_PLAYERS; k++) begin : g_ch
    paddle_channel #(
      .POS_W      (POS_W),
      .MAX_POS    (MAX_POS),
      .CENTER     (CTR),
      .MAX_SPEED  (MAX_SPEED),
      .ACCEL_TICKS(ACCEL_TICKS)
    ) u_ch (
      .clk   (i_clk),
      .reset (i_reset),
      .up    (i_up[k]),
      .down  (i_down[k]),
      .tick  (o_tick),
      .freeze(i_freeze),
      .pos   (o_paddle_pos[k*POS_W +: POS_W])
    );

    assign o_at_top[k]    = (o_paddle_pos[k*POS_W +: POS_W] == '0);
    assign o_at_bottom[k] = (o_paddle_pos[k*POS_W +: POS_W] == POS_W'(MAX_POS));
  end

endmodule

// File: tb/tb_paddle_control_n.sv
// Directed, table-driven bench for paddle_control_n with a small screen and
// a 4-cycle tick so whole ramps fit in a few hundred cycles.
module tb_paddle_control_n;

  localparam int NP = 2, POS_W = 10;
  localparam int MAXP = 48, CTR = 24;

  logic               clk = 1'b0;
  logic               rst;
  logic [NP-1:0]      up, down;
  logic               freeze;
  logic [NP*POS_W-1:0] pos;
  logic [NP-1:0]      at_top, at_bot;
  logic               tick;

  int checks = 0;
  int errors = 0;

  paddle_control_n #(
    .NUM_PLAYERS(NP), .SCREEN_HEIGHT(64), .PADDLE_HEIGHT(16), .POS_W(POS_W),
    .TICK_DIV(4), .MAX_SPEED(3), .ACCEL_TICKS(2)
  ) dut (
    .i_clk(clk), .i_reset(rst), .i_up(up), .i_down(down), .i_freeze(freeze),
    .o_paddle_pos(pos), .o_at_top(at_top), .o_at_bottom(at_bot), .o_tick(tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NP-1:0] up, down;
    logic          fr;
    int            p0, p1;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [NP-1:0] u, logic [NP-1:0] d, logic f, int p0, int p1);
    vec_t v;
    v.up = u; v.down = d; v.fr = f; v.p0 = p0; v.p1 = p1;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_pos(input string tag, input int p0, input int p1);
    check({tag, " pos0"}, int'(pos[0 +: POS_W]), p0);
    check({tag, " pos1"}, int'(pos[POS_W +: POS_W]), p1);
    check({tag, " top"}, int'(at_top), int'({p1 == 0, p0 == 0}));
    check({tag, " bot"}, int'(at_bot), int'({p1 == MAXP, p0 == MAXP}));
  endtask

  // Returns at the negedge one cycle after a tick, so the move is visible.
  task automatic wait_tick();
    bit seen = 0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      if (tick) seen = 1;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL tick_timeout: got no tick expected tick within 8 cycles");
    end
    @(negedge clk);
  endtask

  // Leaves the bench at the negedge of cycle 0 after release.
  task automatic do_reset();
    rst = 1'b1; up = '0; down = '0; freeze = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int seg2[20] = '{47,46,45,43,41,38,35,32,29,26,23,20,17,14,11,8,5,2,0,0};
    int seg1[12] = '{25,26,27,29,31,34,37,40,43,46,48,48};

    // Ramp down on p0 while p1 holds both buttons.
    foreach (seg1[i]) vecs.push_back(mk(2'b10, 2'b11, 1'b0, seg1[i], CTR));
    // Reverse at the bottom, ride to the top.
    foreach (seg2[i]) vecs.push_back(mk(2'b01, 2'b00, 1'b0, seg2[i], CTR));
    // Start a new ramp down.
    vecs.push_back(mk(2'b00, 2'b01, 1'b0, 1, CTR));
    vecs.push_back(mk(2'b00, 2'b01, 1'b0, 2, CTR));
    vecs.push_back(mk(2'b00, 2'b01, 1'b0, 3, CTR));
    vecs.push_back(mk(2'b00, 2'b01, 1'b0, 5, CTR));
    // Freeze mid-ramp for three ticks, p1 requesting up meanwhile.
    repeat (3) vecs.push_back(mk(2'b10, 2'b01, 1'b1, 5, CTR));
    // Release: both channels restart from a 1-line step.
    vecs.push_back(mk(2'b10, 2'b01, 1'b0, 6, 23));
    vecs.push_back(mk(2'b10, 2'b01, 1'b0, 7, 22));
    vecs.push_back(mk(2'b10, 2'b01, 1'b0, 8, 21));
    vecs.push_back(mk(2'b10, 2'b01, 1'b0, 10, 19));

    // Reset values while reset is held.
    rst = 1'b1; up = '0; down = '0; freeze = 1'b0;
    repeat (2) @(negedge clk);
    check_pos("reset", CTR, CTR);
    check("reset tick", int'(tick), 0);

    // Tick phase after release, idle paddles.
    rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) @(negedge clk);
      check($sformatf("tick c%0d", c), int'(tick), (c % 4 == 3) ? 1 : 0);
    end
    @(negedge clk);
    check_pos("idle", CTR, CTR);

    // Table-driven run from a fresh reset.
    do_reset();
    foreach (vecs[i]) begin
      up = vecs[i].up; down = vecs[i].down; freeze = vecs[i].fr;
      wait_tick();
      check_pos($sformatf("vec%0d", i), vecs[i].p0, vecs[i].p1);
    end

    // Reset pulse while p0 is at 40 moving at full speed.
    do_reset();
    down = 2'b01;
    repeat (8) wait_tick();
    check_pos("pre_rst", 40, CTR);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_pos("mid_rst", CTR, CTR);
    for (int c = 0; c < 4; c++) begin
      if (c > 0) @(negedge clk);
      check($sformatf("rst tick c%0d", c), int'(tick), (c == 3) ? 1 : 0);
    end
    @(negedge clk);
    check_pos("post_rst", 25, CTR);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
